// File: rtl/ir_encoder_if.sv
// ---------------------------------------------------------------------------
// ir_encoder_if
// Request/response bundle between a frame requester and the NEC IR encoder.
//   i_start      : request a frame (level; taken while o_ready is high)
//   i_repeat     : 1 = send a repeat frame instead of a full frame
//   i_addr       : address byte, latched at accept
//   i_cmd        : command byte, latched at accept
//   o_ready      : encoder idle and able to take i_start
//   o_done       : one-cycle pulse when the stop mark ends
//   o_ir_tx      : carrier-modulated LED drive
//   o_envelope_n : unmodulated active-low envelope (TSOP polarity)
// master = requester side, slave = encoder side.
// ---------------------------------------------------------------------------
interface ir_encoder_if;
    logic       i_start;
    logic       i_repeat;
    logic [7:0] i_addr;
    logic [7:0] i_cmd;
    logic       o_ready;
    logic       o_done;
    logic       o_ir_tx;
    logic       o_envelope_n;

    modport master (
        output i_start, i_repeat, i_addr, i_cmd,
        input  o_ready, o_done, o_ir_tx, o_envelope_n
    );

    modport slave (
        input  i_start, i_repeat, i_addr, i_cmd,
        output o_ready, o_done, o_ir_tx, o_envelope_n
    );
endinterface

// File: rtl/ir_encoder.sv
// ---------------------------------------------------------------------------
// ir_encoder
// NEC infrared remote transmitter. Serialises either a full frame
// (leader, addr, ~addr, cmd, ~cmd, stop) or a repeat frame (leader,
// short space, stop), followed by a mandatory idle gap.
// Ports:
//   i_clk      : clock
//   i_reset_n  : asynchronous active-low reset
//   bus        : ir_encoder_if.slave (handshake, payload, IR outputs)
// Parameters:
//   UNIT_CYCLES  : clock cycles per NEC unit (562.5 us)
//   CARRIER_HALF : clock cycles per carrier half-period
//   GAP_UNITS    : idle units after the stop mark before o_ready rises
// ---------------------------------------------------------------------------
module ir_encoder #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int GAP_UNITS    = 64
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    ir_encoder_if.slave  bus
);

    localparam int CYC_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int CAR_W    = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int UNIT_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int UNIT_W   = $clog2(UNIT_MAX + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [CAR_W-1:0]  CAR_LAST = CAR_W'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        RPT_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic [4:0]        bit_q, bit_d;
    logic [31:0]       shift_q, shift_d;
    logic              rpt_q, rpt_d;
    logic [CAR_W-1:0]  car_cnt_q, car_cnt_d;
    logic              car_q, car_d;

    logic [UNIT_W-1:0] state_len;
    logic              unit_wrap;
    logic              state_end;

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            unit_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rpt_q     <= 1'b0;
            car_cnt_q <= '0;
            car_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            unit_q    <= unit_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rpt_q     <= rpt_d;
            car_cnt_q <= car_cnt_d;
            car_q     <= car_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rpt_d     = rpt_q;
        car_cnt_d = car_cnt_q;
        car_d     = car_q;
        state_len = UNIT_W'(1);

        // Length in units of the current state; a data space is 3 units
        // for a one bit (LSB of the shift register is the bit on air).
        case (state_q)
            LEAD_MARK:  state_len = UNIT_W'(16);
            LEAD_SPACE: state_len = UNIT_W'(8);
            RPT_SPACE:  state_len = UNIT_W'(4);
            BIT_SPACE:  state_len = shift_q[0] ? UNIT_W'(3) : UNIT_W'(1);
            GAP:        state_len = UNIT_W'(GAP_UNITS);
            default:    state_len = UNIT_W'(1);
        endcase

        unit_wrap = (cyc_q == CYC_LAST);
        state_end = unit_wrap && (unit_q == state_len - UNIT_W'(1));

        if (unit_wrap) begin
            cyc_d  = '0;
            unit_d = unit_q + UNIT_W'(1);
        end else begin
            cyc_d  = cyc_q + CYC_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = LEAD_MARK;
                    rpt_d   = bus.i_repeat;
                    bit_d   = '0;
                    if (!bus.i_repeat) begin
                        shift_d = {~bus.i_cmd, bus.i_cmd, ~bus.i_addr, bus.i_addr};
                    end
                end
            end
            LEAD_MARK:  if (state_end) state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
            LEAD_SPACE: if (state_end) state_d = BIT_MARK;
            RPT_SPACE:  if (state_end) state_d = STOP_MARK;
            BIT_MARK:   if (state_end) state_d = BIT_SPACE;
            BIT_SPACE: begin
                if (state_end) begin
                    shift_d = {1'b0, shift_q[31:1]};
                    bit_d   = bit_q + 5'd1;
                    state_d = (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (state_end) state_d = GAP;
            GAP:        if (state_end) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Timers restart on every state change and stay parked in IDLE.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cyc_d  = '0;
            unit_d = '0;
        end

        // Carrier starts high on the first cycle of every mark. No two marks
        // are adjacent, so "entering a mark" is simply a state change into one.
        if (is_mark(state_d) && (state_d != state_q)) begin
            car_d     = 1'b1;
            car_cnt_d = '0;
        end else if (is_mark(state_d)) begin
            if (car_cnt_q == CAR_LAST) begin
                car_d     = ~car_q;
                car_cnt_d = '0;
            end else begin
                car_cnt_d = car_cnt_q + CAR_W'(1);
            end
        end else begin
            car_d     = 1'b0;
            car_cnt_d = '0;
        end
    end

    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_envelope_n = ~is_mark(state_q);
    assign bus.o_ir_tx      = car_q;
    // First cycle of GAP: counters were cleared by the state change.
    assign bus.o_done       = (state_q == GAP) && (cyc_q == '0) && (unit_q == '0);

endmodule

// File: tb/tb_ir_encoder.sv
// ---------------------------------------------------------------------------
// tb_ir_encoder
// Scoreboard bench for ir_encoder with UNIT_CYCLES=4, CARRIER_HALF=1,
// GAP_UNITS=2. Stimulus pushes the expected envelope segments and the
// expected o_ready low time per frame; a monitor on the falling clock edge
// run-length encodes o_envelope_n / o_ready and compares against the queues.
// ---------------------------------------------------------------------------
module tb_ir_encoder;

    localparam int U  = 4;
    localparam int CH = 1;
    localparam int GU = 2;

    logic clk;
    logic rst_n;

    ir_encoder_if bus ();

    ir_encoder #(
        .UNIT_CYCLES  (U),
        .CARRIER_HALF (CH),
        .GAP_UNITS    (GU)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic lvl;
        int   len;
        logic last;
    } seg_t;

    seg_t exp_q[$];
    int   rdy_q[$];

    int total;
    int bad;
    int flush_cnt;

    // monitor state
    logic mon_prev_env;
    logic mon_prev_rdy;
    logic mon_in_frame;
    int   mon_run;
    int   mon_low_len;
    int   mon_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(input logic lvl, input int len, input logic last);
        seg_t s;
        s.lvl  = lvl;
        s.len  = len;
        s.last = last;
        exp_q.push_back(s);
    endtask

    // Expected envelope of one frame, in cycles, plus the o_ready low time.
    task automatic push_frame(input logic rpt, input logic [7:0] addr,
                              input logic [7:0] cmd, input int rdy_low);
        logic [31:0] w;
        w = {~cmd, cmd, ~addr, addr};
        push_seg(1'b0, 16 * U, 1'b0);
        if (rpt) begin
            push_seg(1'b1, 4 * U, 1'b0);
        end else begin
            push_seg(1'b1, 8 * U, 1'b0);
            for (int i = 0; i < 32; i++) begin
                push_seg(1'b0, U, 1'b0);
                push_seg(1'b1, w[i] ? 3 * U : U, 1'b0);
            end
        end
        push_seg(1'b0, U, 1'b1);
        rdy_q.push_back(rdy_low);
    endtask

    task automatic wait_ready(input int max_cycles);
        int n;
        n = 0;
        while (!bus.o_ready && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.o_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got o_ready=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic send(input logic rpt, input logic [7:0] addr,
                        input logic [7:0] cmd, input int rdy_low);
        wait_ready(1000);
        bus.i_repeat = rpt;
        bus.i_addr   = addr;
        bus.i_cmd    = cmd;
        bus.i_start  = 1'b1;
        push_frame(rpt, addr, cmd, rdy_low);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk("ready_fall_after_accept", bus.o_ready, 0);
        chk("lead_mark_start_env", bus.o_envelope_n, 0);
        chk("lead_mark_start_tx", bus.o_ir_tx, 1);
    endtask

    // Monitor / scoreboard
    initial begin
        logic mark_end;
        seg_t e;
        mon_prev_env = 1'b1;
        mon_prev_rdy = 1'b1;
        mon_in_frame = 1'b0;
        mon_run      = 0;
        mon_low_len  = 0;
        mon_seen     = 0;
        forever begin
            @(negedge clk);
            if (mon_seen != flush_cnt) begin
                mon_seen     = flush_cnt;
                exp_q.delete();
                rdy_q.delete();
                mon_in_frame = 1'b0;
                mon_run      = 0;
                mon_low_len  = 0;
                mon_prev_env = bus.o_envelope_n;
                mon_prev_rdy = bus.o_ready;
            end
            if (rst_n) begin
                mark_end = 1'b0;
                if (bus.o_envelope_n == mon_prev_env) begin
                    mon_run++;
                end else begin
                    if (mon_prev_env == 1'b0) begin
                        mark_end = 1'b1;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL mark_unexpected: got mark of %0d cycles, required none", mon_run);
                        end else begin
                            e = exp_q.pop_front();
                            chk("mark_level", 0, int'(e.lvl));
                            chk("mark_len", mon_run, e.len);
                            chk("done_at_mark_end", int'(bus.o_done), int'(e.last));
                            if (e.last) mon_in_frame = 1'b0;
                        end
                    end else begin
                        if (mon_in_frame) begin
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL space_unexpected: got space of %0d cycles, required none", mon_run);
                            end else begin
                                e = exp_q.pop_front();
                                chk("space_level", 1, int'(e.lvl));
                                chk("space_len", mon_run, e.len);
                            end
                        end
                        mon_in_frame = 1'b1;
                    end
                    mon_run      = 1;
                    mon_prev_env = bus.o_envelope_n;
                end

                if (bus.o_envelope_n == 1'b0)
                    chk("carrier_mark", int'(bus.o_ir_tx), (mon_run % 2 == 1) ? 1 : 0);
                else
                    chk("carrier_space", int'(bus.o_ir_tx), 0);

                if (bus.o_done && !mark_end)
                    chk("done_stray", 1, 0);

                if (!bus.o_ready) begin
                    mon_low_len++;
                end else if (!mon_prev_rdy) begin
                    if (rdy_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ready_unexpected: got ready after %0d low cycles, required none", mon_low_len);
                    end else begin
                        chk("ready_low_len", mon_low_len, rdy_q.pop_front());
                    end
                    mon_low_len = 0;
                end
                mon_prev_rdy = bus.o_ready;
            end
        end
    end

    // Stimulus
    initial begin
        total        = 0;
        bad          = 0;
        flush_cnt    = 0;
        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_repeat = 1'b0;
        bus.i_addr   = 8'h00;
        bus.i_cmd    = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", bus.o_ready, 1);
        chk("reset_env", bus.o_envelope_n, 1);
        chk("reset_tx", bus.o_ir_tx, 0);
        chk("reset_done", bus.o_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", bus.o_ready, 1);
        chk("idle_env", bus.o_envelope_n, 1);

        // Full frame, addr 0x00 cmd 0xFF: 121 units + 2 gap units = 492 cycles
        send(1'b0, 8'h00, 8'hFF, 492);
        wait_ready(600);

        // Repeat frame: 21 units + 2 gap units = 92 cycles
        send(1'b1, 8'h77, 8'h88, 92);
        wait_ready(200);

        // Full frame 0x12/0x34; a start pulse mid-frame must be ignored
        send(1'b0, 8'h12, 8'h34, 492);
        repeat (100) @(posedge clk);
        #1;
        bus.i_addr   = 8'hAA;
        bus.i_cmd    = 8'h55;
        bus.i_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        chk("busy_start_still_busy", bus.o_ready, 0);
        wait_ready(600);
        repeat (20) @(posedge clk);
        #1;
        chk("no_queued_frame_ready", bus.o_ready, 1);
        chk("no_queued_frame_env", bus.o_envelope_n, 1);

        // Start held high: a second repeat frame follows on the first ready cycle
        wait_ready(10);
        bus.i_repeat = 1'b1;
        bus.i_start  = 1'b1;
        push_frame(1'b1, 8'h00, 8'h00, 92);
        push_frame(1'b1, 8'h00, 8'h00, 92);
        @(posedge clk);
        #1;
        wait_ready(200);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk("held_start_reaccept", bus.o_ready, 0);
        wait_ready(200);

        // Reset during the first BIT_SPACE (cycles 101..104 of the frame)
        send(1'b0, 8'h00, 8'hFF, 492);
        repeat (101) @(posedge clk);
        #1;
        chk("pre_reset_space_env", bus.o_envelope_n, 1);
        chk("pre_reset_busy", bus.o_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_ready", bus.o_ready, 1);
        chk("midframe_reset_env", bus.o_envelope_n, 1);
        chk("midframe_reset_tx", bus.o_ir_tx, 0);
        chk("midframe_reset_done", bus.o_done, 0);
        flush_cnt++;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.o_ready, 1);

        // Recovery: a clean full frame after reset
        send(1'b0, 8'hC3, 8'h5A, 492);
        wait_ready(600);

        repeat (20) @(posedge clk);
        #1;
        chk("env_queue_drained", exp_q.size(), 0);
        chk("ready_queue_drained", rdy_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_encoder.md
# ir_encoder

NEC-protocol infrared remote transmitter: the transmit end of the IR link whose receive end is `ir_decoder`. It accepts an 8-bit address and an 8-bit command through a ready/start handshake. It serialises a full NEC frame (leader, address, ~address, command, ~command, stop) or a repeat frame, and drives an IR LED with a 38 kHz-modulated output. An unmodulated, active-low envelope output is also provided so the block can be looped back directly into `ir_decoder` on the same board or in simulation.

## Interface
- `UNIT_CYCLES`, 28125: clock cycles per NEC unit (562.5 us at 50 MHz).
- `CARRIER_HALF`, 658: clock cycles per carrier half-period (about 38 kHz at 50 MHz).
- `GAP_UNITS`, 64: mandatory idle units after the stop mark before `o_ready` rises.
- `i_clk` in 1: 50 MHz clock.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: request a frame; accepted on a rising edge where `o_ready`=1.
- `i_repeat` in 1: sampled with `i_start`; 1 = send a repeat frame, and `i_addr`/`i_cmd` are ignored.
- `i_addr` in 8: address byte, latched at accept.
- `i_cmd` in 8: command byte, latched at accept.
- `o_ready` out 1: 1 when idle and able to accept `i_start`.
- `o_done` out 1: one-cycle pulse when the stop mark ends.
- `o_ir_tx` out 1: modulated LED drive; the carrier is present during marks and the output is 0 otherwise.
- `o_envelope_n` out 1: unmodulated envelope, 0 during mark and 1 during space/idle (TSOP receiver polarity).

## Operation
- States: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8 units), RPT_SPACE (4 units), BIT_MARK (1 unit), BIT_SPACE (1 unit for a 0, 3 units for a 1), STOP_MARK (1 unit), GAP (`GAP_UNITS` units).
- Full frame path: IDLE -> LEAD_MARK -> LEAD_SPACE -> 32 × (BIT_MARK -> BIT_SPACE) -> STOP_MARK -> GAP -> IDLE.
- Repeat frame path: IDLE -> LEAD_MARK -> RPT_SPACE -> STOP_MARK -> GAP -> IDLE.
- Shift register at accept = {~`i_cmd`, `i_cmd`, ~`i_addr`, `i_addr`}. Bits are sent LSB first, so `i_addr`[0] is the first bit on air.
- Bit counter runs 0..31. The last BIT_SPACE (count 31) goes to STOP_MARK.
- Unit timer: a cycle counter (width `$clog2(UNIT_CYCLES)`) wraps at `UNIT_CYCLES`-1. A unit counter (5 bits, max 16; GAP uses a separate 7-bit count or a shared counter sized to max(16, `GAP_UNITS`)) advances on each wrap. The state advances when the unit count reaches the state's length. Both counters clear on every state change.
- Carrier: the counter clears and `o_ir_tx`=1 on the first cycle of every mark state. `o_ir_tx` toggles each time the counter reaches `CARRIER_HALF`-1. It is forced to 0 in every non-mark state.
- `o_envelope_n`=0 exactly in the mark states LEAD_MARK, BIT_MARK and STOP_MARK.
- `o_ready`=1 only in IDLE.
- `i_start` while busy is ignored; it is not queued.
- If `i_start` is held high, a new frame is accepted on the first cycle `o_ready`=1.
- Input changes after accept have no effect on the frame in flight.
- Reset values: state IDLE, `o_ready`=1, `o_done`=0, `o_ir_tx`=0, `o_envelope_n`=1, all counters and the shift register 0.
- Reset mid-frame: all outputs take their reset values immediately (asynchronous). There is no partial-frame completion and no gap enforcement after reset.

## Timing
- Accept on the rising edge at cycle k. LEAD_MARK starts at cycle k+1 with `o_envelope_n`=0 and `o_ir_tx`=1, and `o_ready`=0 from k+1.
- Each state lasts exactly N×`UNIT_CYCLES` cycles, where N is the state's unit length.
- Full frame envelope length is always 16+8+96+1 = 121 units. The 96 units come from 16 zero bits × 2 units plus 16 one bits × 4 units, guaranteed by the complement bytes.
- Repeat frame envelope length is 16+4+1 = 21 units.
- `o_done` is high for exactly the one cycle that is the first cycle of GAP.
- `o_ready` rises at cycle k+1+(121+`GAP_UNITS`)×`UNIT_CYCLES` for a full frame, or k+1+(21+`GAP_UNITS`)×`UNIT_CYCLES` for a repeat frame.
- Carrier period is 2×`CARRIER_HALF` cycles. A mark whose length is not a multiple of the period ends at whatever carrier phase it has reached; there is no extension.

## Test plan
Run with `UNIT_CYCLES`=4, `CARRIER_HALF`=1, `GAP_UNITS`=2.
- Reset then idle: `o_ready`=1, `o_envelope_n`=1, `o_ir_tx`=0, `o_done`=0. Pulsing `i_start` with `o_ready`=1 makes `o_ready` fall on the next cycle.
- Full frame with `i_addr`=0x00, `i_cmd`=0xFF: envelope low 64 cycles, then high 32. The first 8 bits are each low 4/high 4, the next 8 are low 4/high 12, the next 8 low 4/high 12, the last 8 low 4/high 4. Then stop low 4, `o_done` pulses, and `o_ready`=1 after 8 more cycles (total 492 cycles after accept).
- Repeat frame (`i_repeat`=1): envelope low 64, high 16, low 4. `o_done` pulses and `o_ready`=1 at 92 cycles after accept.
- Carrier: during any mark `o_ir_tx` toggles 1,0,1,0 every cycle starting at 1; it is 0 throughout every space and GAP.
- `i_start` pulsed mid-frame with different `i_addr`/`i_cmd`: the frame in flight is unchanged and no second frame starts.
- Assert `i_reset_n`=0 during BIT_SPACE: outputs take their reset values the same cycle. After release, `o_ready`=1. Loopback of `o_envelope_n` into `ir_decoder` for `i_addr`=0x12, `i_cmd`=0x34 (production parameters) yields a valid checksum.
